// File: rtl/if_stage_pkg.sv
// my_pkg: shared width, NOP encoding, fetch FSM states and FIFO entry type
package my_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_TRAP} if_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus (imem request/response, redirect, decode handoff)
// master = fetch stage side, slave = memory/execute/decode environment side
interface if_stage_if;
  import my_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_misalign;
  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr, if_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr, if_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage_fifo.sv
// if_fifo: 2-entry FIFO of if_entry_t with synchronous clear
// ports: clk, rst_n, clear, push/wdata, pop/rdata (head), count (0..2)
module if_fifo
  import my_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  if_entry_t wdata,
  output if_entry_t rdata,
  output logic [1:0] count
);
  localparam if_entry_t RST_E = {{XLEN{1'b0}}, INSTR_NOP};
  if_entry_t mem_q [2];
  if_entry_t mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    wr_d = clear ? 1'b0 : wr_q ^ push;
    rd_d = clear ? 1'b0 : rd_q ^ pop;
    cnt_d = clear ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    if (push && !clear) mem_d[wr_q] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= RST_E;
      mem_q[1] <= RST_E;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with 2-credit imem pipelining, redirect flush and decode buffer
// ports: clk, rst_n (async, active-low), bus (if_stage_if.master)
// IF_MISALIGN_CHECK_EN: misaligned redirect pulses if_misalign and parks in S_TRAP
module if_stage
  import my_pkg::*;
#(
  parameter int XLEN = my_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  if_stage_if.master bus
);
  if_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rpc;
  logic [1:0] out_q, out_d, drop_q, drop_d, pcq_cnt, outq_cnt;
  logic mis_q, mis_d, mis_hit, req, hs, rsp_keep, pop;
  if_entry_t pcq_rd, outq_rd;
  logic unused_bits;
`ifdef IF_MISALIGN_CHECK_EN
  assign rpc = bus.redirect_pc;
  assign mis_hit = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.if_misalign = mis_q;
  // pc_q holds the faulting target during the pulse cycle
  assign bus.if_pc = mis_q ? pc_q : outq_rd.pc;
  assign unused_bits = ^{pcq_rd.instr, pcq_cnt};
`else
  assign rpc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign mis_hit = 1'b0;
  assign bus.if_misalign = 1'b0;
  assign bus.if_pc = outq_rd.pc;
  assign unused_bits = ^{pcq_rd.instr, pcq_cnt, mis_q, bus.redirect_pc[1:0]};
`endif
  // one credit per in-flight request or buffered entry keeps the output FIFO from overflowing
  assign req = state_q == S_FETCH && !bus.redirect_valid && (({1'b0, out_q} + {1'b0, outq_cnt}) < 3'd2);
  assign hs = req && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && drop_q == 2'd0 && !bus.redirect_valid;
  assign pop = bus.if_valid && bus.id_ready;
  assign bus.imem_req_valid = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid = outq_cnt != 2'd0 && !bus.redirect_valid;
  assign bus.if_instr = outq_rd.instr;
  always_comb begin
    pc_d = hs ? pc_q + XLEN'(4) : pc_q;
    out_d = out_q + {1'b0, hs} - {1'b0, bus.imem_rsp_valid};
    drop_d = (bus.imem_rsp_valid && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
    mis_d = mis_hit;
    state_d = (state_q == S_IDLE || (state_q == S_FLUSH && drop_d == 2'd0)) ? S_FETCH : state_q;
    if (bus.redirect_valid) begin
      pc_d = rpc;
      drop_d = out_d;
      state_d = mis_hit ? S_TRAP : (out_d != 2'd0 ? S_FLUSH : S_FETCH);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      out_q <= 2'd0;
      drop_q <= 2'd0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
    end
  end
  if_fifo u_pcq (
    .clk(clk), .rst_n(rst_n), .clear(bus.redirect_valid), .push(hs), .pop(rsp_keep),
    .wdata({pc_q, INSTR_NOP}), .rdata(pcq_rd), .count(pcq_cnt)
  );
  if_fifo u_outq (
    .clk(clk), .rst_n(rst_n), .clear(bus.redirect_valid), .push(rsp_keep), .pop(pop),
    .wdata({pcq_rd.pc, bus.imem_rsp_data}), .rdata(outq_rd), .count(outq_cnt)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random imem/decode/redirect stimulus against a fetch-stream scoreboard
module tb_if_stage;
  import my_pkg::*;
`ifdef IF_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  typedef struct { logic [31:0] addr; int due; } pend_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  if_stage_if bus();
  if_stage #(.RESET_PC(32'h0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pend_t mem_q[$];
  if_entry_t sb_q[$];
  int checks = 0, failures = 0, cyc = 0, last_due = 0, first_vld = -1;
  int rdy_pct = 100, idr_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] exp_fetch = 32'h0, trap_pc = 32'h0;
  bit trapped = 1'b0, mis_exp = 1'b0;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit rd, input logic [31:0] tgt);
    @(negedge clk);
    cyc++;
    bus.redirect_valid = rd;
    bus.redirect_pc = rd ? tgt : $urandom;
    bus.imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
    bus.id_ready = ($urandom_range(1, 100) <= idr_pct);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = $urandom;
    end
  endtask
  // request side: memory model, expected fetch address, scoreboard push/flush
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      int due;
      logic [31:0] rp;
      chk(bus.if_misalign == mis_exp, "if_misalign", 32'(bus.if_misalign), 32'(mis_exp));
      if (mis_exp) chk(bus.if_pc == trap_pc, "trap_if_pc", bus.if_pc, trap_pc);
      if (trapped) chk(!bus.imem_req_valid, "trap_no_req", 32'(bus.imem_req_valid), 0);
      if (bus.redirect_valid) begin
        chk(!bus.imem_req_valid, "redirect_no_req", 32'(bus.imem_req_valid), 0);
        chk(!bus.if_valid, "redirect_no_valid", 32'(bus.if_valid), 0);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk(bus.imem_addr == exp_fetch, "fetch_addr", bus.imem_addr, exp_fetch);
        chk(sb_q.size() < 2, "credit", sb_q.size(), 1);
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{bus.imem_addr, due});
        sb_q.push_back('{pc: bus.imem_addr, instr: instr_of(bus.imem_addr)});
        exp_fetch += 32'd4;
      end
      rp = bus.redirect_pc;
      mis_exp = bus.redirect_valid && MIS_EN && rp[1:0] != 2'b00;
      if (bus.redirect_valid) begin
        sb_q.delete();
        exp_fetch = MIS_EN ? rp : {rp[31:2], 2'b00};
        trapped = mis_exp;
        trap_pc = rp;
      end
    end
  end
  // decode side: pop and compare every accepted instruction
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.if_valid) begin
      if (first_vld < 0) first_vld = cyc;
      if (bus.id_ready) begin
        chk(sb_q.size() != 0, "spurious_output", bus.if_pc, 0);
        if (sb_q.size() != 0) begin
          if_entry_t e;
          e = sb_q.pop_front();
          chk(bus.if_pc == e.pc, "if_pc", bus.if_pc, e.pc);
          chk(bus.if_instr == e.instr, "if_instr", bus.if_instr, e.instr);
        end
      end
    end
  end
  initial begin
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk(!bus.imem_req_valid, "rst_req_valid", 32'(bus.imem_req_valid), 0);
    chk(bus.imem_addr == 32'h0, "rst_imem_addr", bus.imem_addr, 32'h0);
    chk(!bus.if_valid, "rst_if_valid", 32'(bus.if_valid), 0);
    chk(bus.if_pc == 32'h0, "rst_if_pc", bus.if_pc, 32'h0);
    chk(bus.if_instr == 32'h0000_0013, "rst_if_instr", bus.if_instr, 32'h0000_0013);
    chk(!bus.if_misalign, "rst_if_misalign", 32'(bus.if_misalign), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step(1'b0, 32'h0);
    chk(first_vld == 3, "first_valid_cycle", first_vld, 3);
    idr_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    idr_pct = 100;
    repeat (8) step(1'b0, 32'h0);
    lat_min = 3;
    lat_max = 3;
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    repeat (12) step(1'b0, 32'h0);
    lat_min = 1;
    lat_max = 1;
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0040);
    repeat (10) step(1'b0, 32'h0);
    step(1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0102);
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    repeat (10) step(1'b0, 32'h0);
    lat_max = 4;
    rdy_pct = 70;
    idr_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      step($urandom_range(0, 99) < 3, t);
    end
    rdy_pct = 0;
    idr_pct = 100;
    for (int i = 0; i < 60 && (sb_q.size() != 0 || mem_q.size() != 0); i++) step(1'b0, 32'h0);
    chk(sb_q.size() == 0, "drain_sb_empty", sb_q.size(), 0);
    chk(mem_q.size() == 0, "drain_mem_empty", mem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter XLEN, default 32: address/instruction width, taken from the shared package.
REQ-003 clk  in  1  single clock for all state; rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_addr  out  32  fetch address, word aligned.
REQ-008 imem_rsp_valid  in  1  response valid; in order, latency >=1 cycle.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 redirect_valid  in  1  branch/jump/trap redirect from execute.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 if_valid  out  1  instruction available to decode.
REQ-013 id_ready  in  1  decode accepts instruction.
REQ-014 if_pc  out  32  PC of presented instruction.
REQ-015 if_instr  out  32  presented instruction.
REQ-016 if_misalign  out  1  one-cycle pulse, misaligned redirect (macro only).

Function
REQ-017 FSM states: S_IDLE, S_FETCH, S_FLUSH, S_TRAP; S_IDLE -> S_FETCH unconditionally after one cycle.
REQ-018 imem_req_valid = state==S_FETCH && !redirect_valid && (outstanding + fifo_count) < 2.
REQ-019 Request handshake (valid && ready): pc <= pc + 4, mod 2^32 wrap; pc pushed to in-flight PC queue; outstanding += 1.
REQ-020 imem_addr = pc; stable while imem_req_valid held without ready.
REQ-021 Response while not dropping: {in-flight PC head, rsp_data} written to 2-entry output FIFO; outstanding -= 1.
REQ-022 if_valid = FIFO non-empty && !redirect_valid; if_pc/if_instr = FIFO head; pop on if_valid && id_ready.
REQ-023 Fill latency: response in cycle N -> if_valid in cycle N+1; first if_valid no earlier than cycle 3 after rst_n rises.
REQ-024 Credit rule guarantees no FIFO overflow; response with full FIFO is impossible by construction; bench asserts.
REQ-025 Redirect (highest priority, any state): pc <= redirect_pc; FIFO and in-flight queue cleared; drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0).
REQ-026 After redirect: drop_cnt != 0 -> S_FLUSH, else S_FETCH; no request issued in redirect cycle.
REQ-027 S_FLUSH: each response discarded, drop_cnt -= 1; drop_cnt reaching 0 -> S_FETCH; no requests issued.
REQ-028 Redirect during S_FLUSH recomputes drop_cnt per REQ-025 (remaining outstanding counted).
REQ-029 id_ready with redirect_valid in the same cycle: no pop credited, entry discarded.
REQ-030 Simultaneous push and pop on a full FIFO: legal, count unchanged.

Reset
REQ-031 While rst_n low: pc=RESET_PC, state=S_IDLE, FIFO/queue empty, outstanding=0, drop_cnt=0.
REQ-032 Outputs during reset: imem_req_valid=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013, if_misalign=0.
REQ-033 Reset asserted mid-operation abandons all in-flight requests; memory is reset by the same rst_n.

Configuration
REQ-034 Macro IF_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> if_misalign pulse for 1 cycle, if_pc=redirect_pc, state S_TRAP (no requests) until next redirect_valid.
REQ-035 Macro undefined: redirect_pc[1:0] forced to 2'b00; if_misalign tied 0; S_TRAP unreachable.

Structure
REQ-036 Shared package my_pkg holds XLEN, INSTR_NOP (32'h0000_0013), if_state_e enum, if_entry_t struct {pc, instr}.
REQ-037 One sub-module if_fifo: 2-entry synchronous FIFO of if_entry_t, with clear input, used for both output buffer and PC queue.

Verification
REQ-038 Reset release, imem ready=1, latency 1 -> addresses 0x0, 0x4, 0x8 issued; if_pc 0x0 with if_valid in cycle 3.
REQ-039 id_ready=0 for 10 cycles -> at most 2 requests issued, FIFO holds 0x0/0x4, no loss after id_ready=1.
REQ-040 Two outstanding, redirect to 0x100 -> both stale responses dropped, next imem_addr 0x100, first if_pc 0x100.
REQ-041 Redirect in same cycle as a response and id_ready -> drop_cnt=1, no instruction from old stream reaches decode.
REQ-042 pc=0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000.
REQ-043 With IF_MISALIGN_CHECK_EN, redirect 0x102 -> if_misalign pulse, no request until redirect 0x200; without the macro, fetch at 0x100.
